// File: rtl/ram_march_bist.sv
// March-test BIST initiator for a single-port registered-read RAM.
// Runs W(P) up, R(P)W(~P) up, R(~P)W(P) down, R(P) down and records mismatches.
module ram_march_bist #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] pattern,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_M0_W,
    S_M1_R,
    S_M1_W,
    S_M2_R,
    S_M2_W,
    S_M3_R,
    S_M3_C,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] ferr_addr_q, ferr_addr_d;
  logic [DATA_W-1:0] ferr_data_q, ferr_data_d;

  logic              cmp_en;
  logic [DATA_W-1:0] cmp_exp;
  logic              mismatch;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pat_d       = pat_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_d       = err_q;
    ferr_addr_d = ferr_addr_q;
    ferr_data_d = ferr_data_q;
    cmp_en      = 1'b0;
    cmp_exp     = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_M0_W;
          addr_d      = '0;
          pat_d       = pattern;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_d       = '0;
          ferr_addr_d = '0;
          ferr_data_d = '0;
        end
      end
      S_M0_W: begin
        if (addr_q == ADDR_MAX) begin
          state_d = S_M1_R;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_M1_R: state_d = S_M1_W;
      S_M1_W: begin
        cmp_en  = 1'b1;
        cmp_exp = pat_q;
        if (addr_q == ADDR_MAX) begin
          state_d = S_M2_R;
          addr_d  = ADDR_MAX;
        end else begin
          state_d = S_M1_R;
          addr_d  = addr_q + 1'b1;
        end
      end
      S_M2_R: state_d = S_M2_W;
      S_M2_W: begin
        cmp_en  = 1'b1;
        cmp_exp = ~pat_q;
        if (addr_q == '0) begin
          state_d = S_M3_R;
          addr_d  = ADDR_MAX;
        end else begin
          state_d = S_M2_R;
          addr_d  = addr_q - 1'b1;
        end
      end
      S_M3_R: state_d = S_M3_C;
      S_M3_C: begin
        cmp_en  = 1'b1;
        cmp_exp = pat_q;
        if (addr_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_M3_R;
          addr_d  = addr_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase

    // ram_dout here is the word fetched by the preceding read cycle
    mismatch = cmp_en && (ram_dout != cmp_exp);
    if (mismatch) begin
      if (err_q != ERR_MAX) begin
        err_d = err_q + 1'b1;
      end
      if (err_q == '0) begin
        ferr_addr_d = addr_q;
        ferr_data_d = ram_dout;
      end
    end

    if (state_q == S_M3_C && addr_q == '0) begin
      done_d = 1'b1;
      pass_d = (err_d == '0);
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    we_d   = (state_d == S_M0_W) || (state_d == S_M1_W) || (state_d == S_M2_W);
    case (state_d)
      S_M0_W, S_M2_W: din_d = pat_d;
      S_M1_W:         din_d = ~pat_d;
      default:        din_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      pat_q       <= '0;
      we_q        <= 1'b0;
      din_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pat_q       <= pat_d;
      we_q        <= we_d;
      din_q       <= din_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      ferr_addr_q <= ferr_addr_d;
      ferr_data_q <= ferr_data_d;
    end
  end

  assign ram_we         = we_q;
  assign ram_addr       = addr_q;
  assign ram_din        = din_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_addr_q;
  assign first_err_data = ferr_data_q;

endmodule

// File: tb/tb_ram_march_bist.sv
// Self-checking bench for ram_march_bist: table of full March runs against a
// fault-injectable RAM model, plus hand sequences for reset, restart and saturation.
module tb_ram_march_bist;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] pattern;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic       busy, done, pass;
  logic [7:0] err_count;
  logic [3:0] first_err_addr;
  logic [7:0] first_err_data;

  logic       start2;
  logic [7:0] pattern2;
  logic       ram2_we;
  logic [3:0] ram2_addr;
  logic [7:0] ram2_din;
  logic [7:0] ram2_dout;
  logic       busy2, done2, pass2;
  logic [1:0] err2;
  logic [3:0] ferr2_addr;
  logic [7:0] ferr2_data;

  int checks = 0;
  int errors = 0;
  int fault_mode = 0;

  always #5 clk = ~clk;

  ram_march_bist #(.DATA_W(8), .ADDR_W(4), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .first_err_data(first_err_data)
  );

  ram_march_bist #(.DATA_W(8), .ADDR_W(4), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .pattern(pattern2),
    .ram_we(ram2_we), .ram_addr(ram2_addr), .ram_din(ram2_din), .ram_dout(ram2_dout),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_err_addr(ferr2_addr), .first_err_data(ferr2_data)
  );

  // RAM model: registered read, dout holds on write cycles; fault applied on read
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else if (fault_mode == 1 && ram_addr == 4'd5) ram_dout <= mem[ram_addr] | 8'h01;
    else ram_dout <= mem[ram_addr];
  end

  assign ram2_dout = 8'h00;

  typedef struct {
    logic [7:0] pat;
    int         fault;
    bit         pulse;
    int         exp_err;
    logic [3:0] exp_addr;
    logic [7:0] exp_data;
    bit         exp_pass;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Expected RAM port activity in cycle k (1-based) after start acceptance
  task automatic exp_cycle(input int k, input logic [7:0] p,
                           output logic we, output logic [3:0] a, output logic [7:0] d);
    int j;
    j = k - 1;
    if (j < 16) begin
      we = 1'b1; a = 4'(j); d = p;
    end else if (j < 48) begin
      j = j - 16; a = 4'(j / 2); we = j[0]; d = j[0] ? ~p : 8'h00;
    end else if (j < 80) begin
      j = j - 48; a = 4'(15 - j / 2); we = j[0]; d = j[0] ? p : 8'h00;
    end else begin
      j = j - 80; a = 4'(15 - j / 2); we = 1'b0; d = 8'h00;
    end
  endtask

  // Start a run and follow it until busy drops; returns cycle and sequence statistics
  task automatic run_test(input logic [7:0] p, input bit pulse,
                          output int busy_n, output int we_n, output int seq_err);
    logic       ewe;
    logic [3:0] ea;
    logic [7:0] ed;
    busy_n = 0; we_n = 0; seq_err = 0;
    pattern = p;
    start = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (!busy) begin
        start = 1'b0;
        break;
      end
      start = pulse ? (k % 3 == 0) : 1'b0;
      if (pulse) pattern = ~p;
      busy_n++;
      if (ram_we) we_n++;
      exp_cycle(k, p, ewe, ea, ed);
      if (ram_we !== ewe || ram_addr !== ea || ram_din !== ed) seq_err++;
    end
    start = 1'b0;
  endtask

  initial begin
    int bn, wn, se;

    vecs[0] = '{8'hA5, 0, 1'b0, 0, 4'd0, 8'h00, 1'b1};
    vecs[1] = '{8'hA5, 1, 1'b0, 1, 4'd5, 8'h5B, 1'b0};
    vecs[2] = '{8'h5A, 1, 1'b0, 2, 4'd5, 8'h5B, 1'b0};
    vecs[3] = '{8'h3C, 0, 1'b1, 0, 4'd0, 8'h00, 1'b1};
    vecs[4] = '{8'h00, 1, 1'b0, 2, 4'd5, 8'h01, 1'b0};
    vecs[5] = '{8'hFF, 0, 1'b0, 0, 4'd0, 8'h00, 1'b1};

    rst_n = 1'b0; start = 1'b0; pattern = 8'h00; start2 = 1'b0; pattern2 = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {ram_we, ram_addr, ram_din, busy, done, pass, err_count,
                          first_err_addr, first_err_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_hold", {ram_we, ram_addr, busy, done}, 0);

    for (int i = 0; i < 6; i++) begin
      fault_mode = vecs[i].fault;
      run_test(vecs[i].pat, vecs[i].pulse, bn, wn, se);
      $display("vec %0d: pattern=0x%02h fault=%0d busy=%0d we=%0d err=%0d first=%0d/0x%02h pass=%0b",
               i, vecs[i].pat, vecs[i].fault, bn, wn, err_count, first_err_addr,
               first_err_data, pass);
      chk($sformatf("v%0d_busy_cycles", i), bn, 112);
      chk($sformatf("v%0d_we_cycles", i), wn, 48);
      chk($sformatf("v%0d_seq_mismatches", i), se, 0);
      chk($sformatf("v%0d_done", i), done, 1);
      chk($sformatf("v%0d_pass", i), pass, vecs[i].exp_pass);
      chk($sformatf("v%0d_err_count", i), err_count, vecs[i].exp_err);
      chk($sformatf("v%0d_first_addr", i), first_err_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_first_data", i), first_err_data, vecs[i].exp_data);
      chk($sformatf("v%0d_done_port", i), {ram_we, ram_addr, ram_din}, 0);
    end

    // Restart from DONE with stale errors present
    fault_mode = 1;
    run_test(8'hA5, 1'b0, bn, wn, se);
    chk("pre_restart_err", err_count, 1);
    pattern = 8'h3C; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    $display("restart: done=%0b busy=%0b err=%0d we=%0b din=0x%02h", done, busy, err_count,
             ram_we, ram_din);
    chk("restart_cleared", {done, pass, err_count, first_err_addr, first_err_data}, 0);
    chk("restart_first_cycle", {busy, ram_we, ram_addr, ram_din}, {1'b1, 1'b1, 4'd0, 8'h3C});
    for (int k = 0; k < 200 && busy; k++) @(negedge clk);
    chk("restart_done", done, 1);
    chk("restart_err", err_count, 2);
    chk("restart_first", {first_err_addr, first_err_data}, {4'd5, 8'h3D});

    // Reset asserted during M1
    fault_mode = 0;
    pattern = 8'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    chk("mid_m1_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    $display("mid-test reset: busy=%0b we=%0b addr=%0d", busy, ram_we, ram_addr);
    chk("mid_reset_outputs", {ram_we, ram_addr, ram_din, busy, done, pass, err_count,
                              first_err_addr, first_err_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {busy, ram_we, done}, 0);
    run_test(8'h3C, 1'b0, bn, wn, se);
    $display("after reset: pattern=0x3c busy=%0d pass=%0b err=%0d", bn, pass, err_count);
    chk("post_reset_busy_cycles", bn, 112);
    chk("post_reset_seq", se, 0);
    chk("post_reset_pass", {done, pass, err_count}, {1'b1, 1'b1, 8'd0});

    // All words read 0x00 with a 2-bit error counter
    pattern2 = 8'hFF; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 0; k < 200 && busy2; k++) @(negedge clk);
    $display("stuck-0: done=%0b err=%0d first=%0d/0x%02h pass=%0b", done2, err2, ferr2_addr,
             ferr2_data, pass2);
    chk("sat_done", done2, 1);
    chk("sat_err_count", err2, 3);
    chk("sat_first", {ferr2_addr, ferr2_data}, 0);
    chk("sat_pass", pass2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
